// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between uart_rx_ctrl, its UART receiver and the CPU read side.
// The controller takes the slave modport; the driving environment takes master.
interface uart_rx_ctrl_if #(
  parameter int DIV_WIDTH  = 16,
  parameter int DEPTH_LOG2 = 4
);
  logic [DIV_WIDTH-1:0]  baud_div;
  logic                  clken;
  logic                  rx_rdy;
  logic [7:0]            rx_data;
  logic                  rdy_clr;
  logic                  rd_en;
  logic [7:0]            rd_data;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overrun;
  logic                  ovr_clr;
  logic                  irq;

  modport slave (
    input  baud_div, rx_rdy, rx_data, rd_en, ovr_clr,
    output clken, rdy_clr, rd_data, empty, full, count, overrun, irq
  );

  modport master (
    output baud_div, rx_rdy, rx_data, rd_en, ovr_clr,
    input  clken, rdy_clr, rd_data, empty, full, count, overrun, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversample strobe, byte capture/acknowledge, RX FIFO.
// Optional receive timeout interrupt enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int DIV_WIDTH  = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  uart_rx_ctrl_if.slave    bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = DEPTH_LOG2'(0) | (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] HALF_C  = (DEPTH_LOG2+1)'(DEPTH / 2);

  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  clken_q, clken_d;
  logic                  rx_rdy_q;
  logic                  rdy_clr_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            mem [DEPTH];

  logic capture, push, pop, drop, empty_w, full_w;

  // Oversample divider: strobe on reload, so baud_div changes land at the next reload.
  always_comb begin
    cnt_d   = cnt_q - 1'b1;
    clken_d = 1'b0;
    if (cnt_q == '0) begin
      cnt_d   = bus.baud_div;
      clken_d = 1'b1;
    end
  end

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);
  assign capture = bus.rx_rdy & ~rx_rdy_q;
  assign pop     = bus.rd_en & ~empty_w;
  // When full, a simultaneous pop frees the slot the new byte goes into.
  assign push    = capture & (~full_w | pop);
  assign drop    = capture & full_w & ~pop;

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
    overrun_d = overrun_q;
    if (bus.ovr_clr) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clken_q   <= 1'b0;
      rx_rdy_q  <= 1'b0;
      rdy_clr_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clken_q   <= clken_d;
      rx_rdy_q  <= bus.rx_rdy;
      rdy_clr_q <= capture;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage has no reset so it maps onto plain distributed RAM.
  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr_q] <= bus.rx_data;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [9:0] TMO_LIMIT = 10'd640;
  logic [9:0] tmo_cnt_q, tmo_cnt_d;
  logic       timeout_q, timeout_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    if (push | pop) begin
      tmo_cnt_d = '0;
      timeout_d = 1'b0;
    end else if (!empty_w && clken_q && tmo_cnt_q != TMO_LIMIT) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_d == TMO_LIMIT) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.irq = timeout_q | (count_q >= HALF_C) | overrun_q;
`else
  assign bus.irq = ~empty_w | overrun_q;
`endif

  assign bus.clken   = clken_q;
  assign bus.rdy_clr = rdy_clr_q;
  assign bus.rd_data = mem[rd_ptr_q];
  assign bus.empty   = empty_w;
  assign bus.full    = full_w;
  assign bus.count   = count_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (default build; timeout case
// is added when UART_RX_TIMEOUT_EN is defined).
module tb_uart_rx_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   hits;

  uart_rx_ctrl_if #(.DIV_WIDTH(16), .DEPTH_LOG2(4)) u_if ();

  uart_rx_ctrl #(.DIV_WIDTH(16), .DEPTH_LOG2(4)) u_dut (
    .clk_50m (clk),
    .rst_n   (rst_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Raise rx_rdy for one cycle; returns at the negedge of the cycle after capture.
  task automatic rx_pulse(input logic [7:0] b);
    u_if.rx_data = b;
    u_if.rx_rdy  = 1'b1;
    @(negedge clk);
    u_if.rx_rdy  = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_pulse(b);
    @(negedge clk);
  endtask

  task automatic pop_byte();
    u_if.rd_en = 1'b1;
    @(negedge clk);
    u_if.rd_en = 1'b0;
  endtask

  task automatic count_clken(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (u_if.clken) h++;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    u_if.baud_div = 16'd26;
    u_if.rx_rdy = 1'b0;
    u_if.rx_data = 8'h00;
    u_if.rd_en = 1'b0;
    u_if.ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clken", u_if.clken, 0);
    check("rst_rdy_clr", u_if.rdy_clr, 0);
    check("rst_empty", u_if.empty, 1);
    check("rst_full", u_if.full, 0);
    check("rst_count", u_if.count, 0);
    check("rst_overrun", u_if.overrun, 0);
    check("rst_irq", u_if.irq, 0);

    // Divider: first strobe one edge after release, then every 27 cycles.
    rst_n = 1'b1;
    @(negedge clk);
    check("clken_first", u_if.clken, 1);
    count_clken(26, hits);
    check("clken_gap26", hits, 0);
    @(negedge clk);
    check("clken_period27", u_if.clken, 1);
    u_if.baud_div = 16'd3;
    count_clken(26, hits);
    check("clken_old_div_holds", hits, 0);
    @(negedge clk);
    check("clken_reload", u_if.clken, 1);
    count_clken(3, hits);
    check("clken_gap3", hits, 0);
    @(negedge clk);
    check("clken_period4", u_if.clken, 1);

    // Single byte.
    rx_pulse(8'hA5);
    check("single_rdy_clr", u_if.rdy_clr, 1);
    check("single_count", u_if.count, 1);
    check("single_rd_data", u_if.rd_data, 8'hA5);
    check("single_irq", u_if.irq, 1);
    @(negedge clk);
    check("single_rdy_clr_off", u_if.rdy_clr, 0);
    pop_byte();
    check("single_pop_empty", u_if.empty, 1);
    check("single_pop_irq", u_if.irq, 0);

    // Held rx_rdy gives exactly one capture.
    u_if.rx_data = 8'h11;
    u_if.rx_rdy = 1'b1;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (u_if.rdy_clr) hits++;
    end
    u_if.rx_rdy = 1'b0;
    @(negedge clk);
    if (u_if.rdy_clr) hits++;
    check("hold_rdy_clr_pulses", hits, 1);
    check("hold_count", u_if.count, 1);
    check("hold_rd_data", u_if.rd_data, 8'h11);
    pop_byte();

    // Fill, overflow, drain in order, pointer wrap.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill_full", u_if.full, 1);
    check("fill_count", u_if.count, 16);
    push_byte(8'hFF);
    check("ovf_overrun", u_if.overrun, 1);
    check("ovf_count", u_if.count, 16);
    u_if.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), u_if.rd_data, 32'(i));
      @(negedge clk);
    end
    u_if.rd_en = 1'b0;
    check("drain_empty", u_if.empty, 1);
    push_byte(8'h42);
    check("wrap_rd_data", u_if.rd_data, 8'h42);
    pop_byte();
    check("wrap_empty", u_if.empty, 1);
    check("ovf_irq_sticky", u_if.irq, 1);
    u_if.ovr_clr = 1'b1;
    @(negedge clk);
    u_if.ovr_clr = 1'b0;
    check("ovr_clr", u_if.overrun, 0);

    // Full plus simultaneous capture and pop.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    u_if.rd_en = 1'b1;
    rx_pulse(8'h77);
    u_if.rd_en = 1'b0;
    check("fullrw_count", u_if.count, 16);
    check("fullrw_overrun", u_if.overrun, 0);
    check("fullrw_head", u_if.rd_data, 8'h21);
    u_if.rd_en = 1'b1;
    for (int i = 0; i < 15; i++) @(negedge clk);
    u_if.rd_en = 1'b0;
    check("fullrw_last", u_if.rd_data, 8'h77);
    check("fullrw_last_count", u_if.count, 1);
    pop_byte();

    // Set beats clear when both happen in one cycle.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    u_if.ovr_clr = 1'b1;
    rx_pulse(8'hEE);
    u_if.ovr_clr = 1'b0;
    check("ovr_set_wins", u_if.overrun, 1);

    // Asynchronous reset mid-operation.
    #2 rst_n = 1'b0;
    #1;
    check("midrst_count", u_if.count, 0);
    check("midrst_empty", u_if.empty, 1);
    check("midrst_overrun", u_if.overrun, 0);

`ifdef UART_RX_TIMEOUT_EN
    u_if.baud_div = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rx_pulse(8'h5A);
    check("tmo_irq_start", u_if.irq, 0);
    repeat (639) @(negedge clk);
    check("tmo_irq_before", u_if.irq, 0);
    @(negedge clk);
    check("tmo_irq_at_640", u_if.irq, 1);
    pop_byte();
    check("tmo_irq_cleared", u_if.irq, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. It generates the receiver's 16x oversampling enable from a programmable divisor, captures each completed byte, and acknowledges it with `rdy_clr`. Captured bytes are buffered in a small circular FIFO for the CPU bus side, which sees show-ahead read data, level/status flags, a sticky overrun flag and an interrupt request.

## Interface
- `DIV_WIDTH`, 16: width of the baud divisor and its counter.
- `DEPTH_LOG2`, 4: log2 of FIFO depth; default depth is 16 bytes.
- `clk_50m`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `baud_div`  in  DIV_WIDTH  oversample period minus 1. `clken` period is `baud_div+1` clocks; 26 gives 115200 baud x16.
- `clken`  out  1  one-cycle oversample strobe to the receiver.
- `rx_rdy`  in  1  byte-complete flag from the receiver.
- `rx_data`  in  8  received byte from the receiver.
- `rdy_clr`  out  1  one-cycle acknowledge to the receiver.
- `rd_en`  in  1  pop the FIFO head.
- `rd_data`  out  8  FIFO head byte; valid while `empty`=0.
- `empty`  out  1  FIFO holds 0 bytes.
- `full`  out  1  FIFO holds `2^DEPTH_LOG2` bytes.
- `count`  out  DEPTH_LOG2+1  bytes held.
- `overrun`  out  1  sticky; a byte was dropped.
- `ovr_clr`  in  1  clear `overrun`.
- `irq`  out  1  interrupt request, level-sensitive.

## Operation
- Baud counter `cnt` (DIV_WIDTH bits):
  - If `cnt`==0: load `baud_div` and register `clken`=1.
  - Else: decrement `cnt` and register `clken`=0.
  - A new `baud_div` value takes effect at the next reload.
  - `baud_div`=0 makes `clken` stay high every cycle.
- Capture:
  - Rising-edge detect on `rx_rdy` using a registered `rx_rdy_q`. A level held high counts as one capture.
  - On a capture cycle, `rx_data` is sampled in that same cycle.
  - `rdy_clr` pulses for exactly one cycle, in the cycle after each capture.
- FIFO: circular buffer with `wr_ptr`/`rd_ptr` of DEPTH_LOG2 bits, wrapping modulo depth. `count` is tracked separately.
  - Push if capture and not full.
  - Capture while full and `rd_en`=0: byte is dropped, `overrun` is set, FIFO is unchanged.
  - Capture while full with `rd_en`=1 in the same cycle: push and pop both happen; `count` stays at full; `overrun` is not set.
  - Push and pop in the same cycle when not empty: `count` is unchanged.
  - `rd_en` while empty is ignored; pointers and `count` do not change.
- `rd_data` = `mem[rd_ptr]` (combinational from the register array). After a pop, the next byte appears in the following cycle.
- `overrun`:
  - Cleared by `ovr_clr`.
  - If a set event and `ovr_clr` occur in the same cycle, set wins.
- `irq` (default build) = !`empty` | `overrun`.

## Timing
- Reset values: `clken`=0, `rdy_clr`=0, `rx_rdy_q`=0, `cnt`=0, pointers=0, `count`=0, `empty`=1, `full`=0, `overrun`=0, `irq`=0. `rd_data` reads `mem[0]`, which is undefined after reset.
- First `clken` occurs on the first clock edge after `rst_n` deasserts.
- Capture-to-visibility latency:
  - `rx_rdy` rises in cycle N.
  - Byte is written at the N edge.
  - `empty`=0, `count`+1 and `rd_data` valid in cycle N+1.
  - `rdy_clr`=1 in cycle N+1.
- Pop latency: `rd_en` in cycle N updates `rd_ptr`/`count` in cycle N+1.
- `empty`, `full`, `count`, `overrun` and `irq` are all registered or derived only from registers, so there are no combinational input-to-output paths.
- Reset asserted mid-operation clears all state immediately, dropping buffered bytes and any pending `rdy_clr`.

## Configuration
- `UART_RX_TIMEOUT_EN` defined: adds a receive timeout.
  - A 10-bit counter of `clken` pulses runs while !`empty`.
  - It is cleared on every push or pop.
  - On reaching 640 (4 characters x 10 bits x 16 samples), it sets sticky `timeout`.
  - `timeout` is cleared by the next push or pop, or by reset.
  - `irq` = `timeout` | (`count` >= depth/2) | `overrun`.
- `UART_RX_TIMEOUT_EN` undefined: no timeout counter; `irq` = !`empty` | `overrun`.

## Test plan
- Reset, then `baud_div`=26 -> `clken` high on cycle 1 after `rst_n`↑, then every 27 cycles. Change `baud_div` to 3 mid-count -> period becomes 4 only after the next reload.
- Single byte: pulse `rx_rdy` with `rx_data`=0xA5 -> next cycle `rdy_clr`=1 for one cycle, `count`=1, `rd_data`=0xA5, `irq`=1. Then `rd_en` -> `empty`=1, `irq`=0.
- Hold `rx_rdy` high for 5 cycles with `rx_data`=0x11 -> exactly one push, one `rdy_clr`.
- Push 16 bytes 0x00..0x0F -> `full`=1, `count`=16. Push 0xFF -> dropped, `overrun`=1. Pop all -> 0x00..0x0F in order. Pointers wrap: a further push/pop of 0x42 reads back 0x42.
- Full FIFO plus capture of 0x77 with `rd_en` in the same cycle -> `count` stays 16, `overrun`=0, 0x77 read last. `ovr_clr` together with an overrun event -> `overrun`=1.
- (`UART_RX_TIMEOUT_EN`) 1 byte buffered, `baud_div`=0 -> `irq`=0 until 640 `clken` pulses, then `irq`=1; `rd_en` clears it.
